// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO.
// Default geometry plus the pointer-width helper.
package sync_fifo_pkg;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int FIFO_WIDTH_DEF = 3;
    localparam int PTR_W_DEF      = $clog2(FIFO_DEPTH_DEF);
endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array with a registered read port.
// The array itself is never reset; only the read register is.
module sync_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register holds its last value when no read is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flags and rd_vld.
// Optional sticky error flags under SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  rd_vld,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  fifo_empty,
    output logic                  fifo_full
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  wr_overflow,
    output logic                  rd_underflow
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             rd_vld_d, rd_vld_q;
    logic             wr_acc;
    logic             rd_acc;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // Flags come from the registered count, so full+both favours the
    // read and empty+both favours the write.
    always_comb begin
        wr_acc   = wr_en & ~fifo_full;
        rd_acc   = rd_en & ~fifo_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_vld_d = rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign rd_vld = rd_vld_q;

    sync_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_d, ovf_q;
    logic udf_d, udf_q;

    always_comb begin
        ovf_d = ovf_q | (wr_en & fifo_full);
        udf_d = udf_q | (rd_en & fifo_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign wr_overflow  = ovf_q;
    assign rd_underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based model.
// Build with SYNC_FIFO_ERR_FLAGS_EN to also check the sticky flags.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int W     = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en = 1'b0;
    logic         rd_vld;
    logic [W-1:0] rd_data;
    logic         fifo_empty;
    logic         fifo_full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic         wr_overflow;
    logic         rd_underflow;
`endif

    int tests = 0;
    int fails = 0;

    logic [W-1:0] q[$];
    logic         exp_vld = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_ovf = 1'b0;
    logic         exp_udf = 1'b0;

    sync_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FIFO_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .wr_overflow  (wr_overflow),
        .rd_underflow (rd_underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("rd_vld", 32'(rd_vld), 32'(exp_vld));
        check("rd_data", 32'(rd_data), 32'(exp_data));
        check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
        check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("wr_overflow", 32'(wr_overflow), 32'(exp_ovf));
        check("rd_underflow", 32'(rd_underflow), 32'(exp_udf));
`endif
    endtask

    // One clock edge: model decides acceptance from pre-edge occupancy.
    task automatic step();
        bit full_m  = (q.size() == DEPTH);
        bit empty_m = (q.size() == 0);
        bit wa      = wr_en && !full_m;
        bit ra      = rd_en && !empty_m;
        @(posedge clk);
        if (wr_en && full_m) exp_ovf = 1'b1;
        if (rd_en && empty_m) exp_udf = 1'b1;
        if (ra) begin
            exp_data = q.pop_front();
            exp_vld  = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        if (wa) q.push_back(wr_data);
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        q.delete();
        exp_vld  = 1'b0;
        exp_data = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    initial begin
        int sent;
        int rcv;
        int pause;
        int vcnt;
        bit done;

        // Reset and idle
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk) rst = 1'b1;
        step();
        rd_en = 1'b1;
        step();
        step();
        rd_en = 1'b0;
        step();

        // Write 0..3 then read 4
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = W'(i);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("seq4_data", 32'(rd_data), i);
        end
        rd_en = 1'b0;
        step();

        // Fill, overflow attempt, drain
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = W'(i);
            step();
        end
        check("full_after_8", 32'(fifo_full), 1);
        wr_data = 3'd5;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fill_data", 32'(rd_data), i);
        end
        step();
        rd_en = 1'b0;
        check("empty_after_drain", 32'(fifo_empty), 1);

        // Concurrent random stream with a read pause
        sent = 0;
        rcv = 0;
        pause = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            wr_en = (sent < 100) && !fifo_full && ($urandom_range(0, 3) != 0);
            wr_data = W'(sent);
            if (rcv == 50 && pause < 10) begin
                rd_en = 1'b0;
                pause++;
            end else begin
                rd_en = ($urandom_range(0, 2) != 0);
            end
            if (wr_en) sent++;
            step();
            if (exp_vld) begin
                check("stream_order", 32'(rd_data), 32'(rcv % 8));
                rcv++;
            end
            done = (rcv == 100);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("stream_done", 32'(done), 1);
        step();

        // Full with both enables: read wins, write dropped
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = W'($urandom);
            step();
        end
        rd_en = 1'b1;
        wr_data = 3'd5;
        step();
        wr_en = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_vld) vcnt++;
        end
        rd_en = 1'b0;
        check("count_after_full_rw", vcnt, 7);
        step();

        // Mid-stream asynchronous reset with 5 stored
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = W'($urandom);
            step();
        end
        wr_en = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk) rst = 1'b1;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = W'($urandom);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rd_en = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous single-clock FIFO for fixed-width data words, sitting between a producer that pushes with a write enable and a consumer that pops with a read enable. Read data is registered and qualified by a one-cycle-delayed valid strobe. Full and empty status flags let both sides throttle themselves. Overflowing writes and underflowing reads are dropped, never corrupting state.

## Interface
Parameters:
- FIFO_DEPTH, 8: number of entries; power of two, at least 2.
- FIFO_WIDTH, 3: data word width in bits.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request, sampled on the rising edge.
- wr_data  input  FIFO_WIDTH  data to write when wr_en=1.
- rd_en  input  1  read request, sampled on the rising edge.
- rd_vld  output  1  registered; rd_data is valid this cycle.
- rd_data  output  FIFO_WIDTH  registered read data.
- fifo_empty  output  1  no stored entries.
- fifo_full  output  1  FIFO_DEPTH entries stored.
- (with SYNC_FIFO_ERR_FLAGS_EN) wr_overflow  output  1  sticky; a write was dropped while full.
- (with SYNC_FIFO_ERR_FLAGS_EN) rd_underflow  output  1  sticky; a read was dropped while empty.

## Operation
- Storage: FIFO_DEPTH x FIFO_WIDTH array. Write pointer and read pointer are each $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- Write accepted when wr_en=1 and fifo_full=0: mem[wr_ptr]<=wr_data, wr_ptr increments.
- Write while full: dropped. Pointers, count and memory are unchanged.
- Read accepted when rd_en=1 and fifo_empty=0: rd_data<=mem[rd_ptr], rd_ptr increments, rd_vld<=1.
- Read while empty: ignored, and rd_vld<=0.
- Any non-accepted cycle: rd_vld<=0, and rd_data holds its last value.
- Count: +1 on a write alone, -1 on a read alone. A simultaneous accepted read and write leaves the count unchanged.
- Full and empty: both flags are evaluated on the registered count before the edge. When full and both enables are asserted, only the read is accepted. When empty and both are asserted, only the write is accepted.
- Flags: fifo_empty = (count==0) and fifo_full = (count==FIFO_DEPTH), both derived combinationally from the registered count.
- Ordering: strict first-in, first-out. Data read out equals data written, in write order, across pointer wrap-around.

## Timing
- Reset (rst=0, asynchronous): pointers=0, count=0, rd_vld=0, rd_data=0, fifo_empty=1, fifo_full=0, and any error flags=0. The memory array is not reset.
- Reset asserted mid-operation empties the FIFO immediately. Stored contents are discarded.
- Read latency: rd_en accepted at edge N gives rd_vld=1 with rd_data during cycle N..N+1, i.e. after edge N.
- Write-to-empty: a write at edge N clears fifo_empty after edge N. The earliest accepted read of that word is at edge N+1.
- Throughput: one write and one read per cycle sustained.
- fifo_full asserts after the edge that stores entry FIFO_DEPTH. It deasserts after the first subsequent accepted read.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined: adds the wr_overflow and rd_underflow output ports.
  - wr_overflow sets on a dropped write (wr_en=1 while full).
  - rd_underflow sets on a dropped read (rd_en=1 while empty).
  - Both flags are sticky and are cleared only by reset.
- SYNC_FIFO_ERR_FLAGS_EN undefined: these ports and their logic are absent. Data-path behaviour is identical in both builds.

## Structure
- Package sync_fifo_pkg holds the default depth and width constants and a pointer-width helper constant, $clog2(FIFO_DEPTH).
- Sub-module sync_fifo_mem is a simple dual-port register array: write port (we, waddr, wdata) and registered read port (re, raddr, rdata). It contains no reset on the array.
- The top level holds the pointers, the counter, the flags, rd_vld and the optional error flags.

## Test plan
- Reset then idle: expect fifo_empty=1, fifo_full=0, rd_vld=0 and rd_data=0. Pulsing rd_en while empty must not assert rd_vld.
- Write 0,1,2,3 on consecutive cycles, then read 4 cycles: expect rd_vld on 4 consecutive cycles with rd_data 0,1,2,3, and fifo_empty=1 after the last read.
- Write 0..7: fifo_full=1 after the 8th write. A 9th write of 5 is dropped. Reads then return 0..7 only, and wr_overflow=1 when the flag is compiled in.
- Concurrent stream of 0..99 writes with reads, where reads pause for 10 cycles after 50 pops: all 100 values return in order, including through wrap-around. No dropped writes occur, because the writer throttles on fifo_full.
- Full FIFO with wr_en=rd_en=1 on one edge: read of the oldest word is accepted, the write is dropped, and count becomes 7.
- Assert rst low mid-stream with 5 entries stored: flags return to their reset values immediately. A subsequent read is ignored, and new writes restart from pointer 0.
